// File: rtl/gumnut_port_timer.sv
`default_nettype none
// ============================================================================
//  Module   : gumnut_port_timer
//  Purpose  : Programmable 8-bit down-counter timer on the Gumnut I/O port
//             bus. An 8-bit prescaler divides the clock into ticks. Each tick
//             decrements COUNT. When COUNT reaches 0, the next tick expires
//             the timer and either reloads (AUTO) or stops (one-shot). An
//             expiry sets EXP, which drives a maskable interrupt request.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i      in   1  system clock
//    rst_i      in   1  asynchronous active-low reset
//    cyc_i      in   1  port bus cycle qualifier
//    stb_i      in   1  port bus strobe
//    we_i       in   1  write enable
//    adr_i      in   8  port address
//    dat_i      in   8  write data
//    ack_o      out  1  registered one-cycle acknowledge
//    dat_o      out  8  read data, zero whenever ack_o is low
//    int_ack_i  in   1  interrupt acknowledge (clears EXP)
//    int_req_o  out  1  registered interrupt request (EXP & IE)
//  Register map (offset from BASE_ADDR)
//    0 CTRL     rw   [0] EN, [1] AUTO, [2] IE
//    1 STATUS        [0] EXP (write 1 to clear), [1] EN (read-only)
//    2 RELOAD   rw
//    3 COUNT    rw   read returns the live count; write loads the counter
//    4 PRESCALE rw   writing restarts the prescaler
// ============================================================================
module gumnut_port_timer #(
  parameter logic [7:0] BASE_ADDR    = 8'hF0,
  parameter logic [7:0] RESET_RELOAD = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [7:0] adr_i,
  input  logic [7:0] dat_i,
  output logic       ack_o,
  output logic [7:0] dat_o,
  input  logic       int_ack_i,
  output logic       int_req_o
);

  // Address decode and bus qualification
  logic [2:0] offset;
  logic       base_match;
  logic       decoded;
  logic       hit;
  logic       wr;
  logic       wr_ctrl;
  logic       wr_status;
  logic       wr_reload;
  logic       wr_count;
  logic       wr_prescale;

  // Register state
  logic       en;
  logic       auto_rl;
  logic       ie;
  logic       exp_flag;
  logic [7:0] reload;
  logic [7:0] count;
  logic [7:0] prescale;
  logic [7:0] presc_cnt;

  // Timing events
  logic       tick;
  logic       expire;
  logic       exp_clear;

  // Bus response
  logic [7:0] rd_data;
  logic       ack_q;
  logic [7:0] dat_q;
  logic       int_req_q;

  assign offset     = adr_i[2:0];
  // BASE_ADDR is 8-aligned, so the upper five bits select the block and the
  // low three bits select a register; offsets 5..7 are left undecoded.
  assign base_match = (adr_i[7:3] == BASE_ADDR[7:3]);
  assign decoded    = base_match && (offset <= 3'd4);

  // Gating with the registered ack forces a gap after every acknowledge, so
  // a master holding stb_i sees ack on alternate cycles only.
  assign hit        = cyc_i && stb_i && decoded && !ack_q;
  assign wr         = hit && we_i;

  assign wr_ctrl     = wr && (offset == 3'd0);
  assign wr_status   = wr && (offset == 3'd1);
  assign wr_reload   = wr && (offset == 3'd2);
  assign wr_count    = wr && (offset == 3'd3);
  assign wr_prescale = wr && (offset == 3'd4);

  assign tick      = en && (presc_cnt == prescale);
  assign expire    = tick && (count == 8'd0);
  assign exp_clear = int_ack_i || (wr_status && dat_i[0]);

  // Read multiplexer, sampled into dat_q on the hit cycle
  always_comb begin
    rd_data = 8'h00;
    case (offset)
      3'd0:    rd_data = {5'b00000, ie, auto_rl, en};
      3'd1:    rd_data = {6'b000000, en, exp_flag};
      3'd2:    rd_data = reload;
      3'd3:    rd_data = count;
      3'd4:    rd_data = prescale;
      default: rd_data = 8'h00;
    endcase
  end

  // Bus acknowledge and read data. Write acks return zero data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 8'h00;
    end else begin
      ack_q <= hit;
      dat_q <= (hit && !we_i) ? rd_data : 8'h00;
    end
  end

  // Prescaler: counts 0..PRESCALE while enabled, held at 0 otherwise
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prescale  <= 8'h00;
      presc_cnt <= 8'h00;
    end else begin
      if (wr_prescale) begin
        prescale <= dat_i;
      end
      if (wr_prescale || !en || tick) begin
        presc_cnt <= 8'h00;
      end else begin
        presc_cnt <= presc_cnt + 8'd1;
      end
    end
  end

  // Reload and count. A bus write to COUNT takes priority over a tick.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reload <= RESET_RELOAD;
      count  <= RESET_RELOAD;
    end else begin
      if (wr_reload) begin
        reload <= dat_i;
      end
      if (wr_count) begin
        count <= dat_i;
      end else if (tick) begin
        if (count != 8'd0) begin
          count <= count - 8'd1;
        end else if (auto_rl) begin
          count <= reload;
        end
      end
    end
  end

  // Control. A one-shot expiry clears EN unless the bus writes CTRL in the
  // same cycle, in which case the written value stands.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en      <= dat_i[0];
        auto_rl <= dat_i[1];
        ie      <= dat_i[2];
      end else if (expire && !auto_rl) begin
        en <= 1'b0;
      end
    end
  end

  // Expiry flag (set beats clear) and the interrupt request, which follows
  // the registered EXP & IE one cycle later.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      exp_flag  <= 1'b0;
      int_req_q <= 1'b0;
    end else begin
      if (expire) begin
        exp_flag <= 1'b1;
      end else if (exp_clear) begin
        exp_flag <= 1'b0;
      end
      int_req_q <= exp_flag && ie;
    end
  end

  assign ack_o     = ack_q;
  assign dat_o     = dat_q;
  assign int_req_o = int_req_q;

endmodule
`default_nettype wire

// File: tb/tb_gumnut_port_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_gumnut_port_timer
//  Purpose  : Self-checking bench for gumnut_port_timer. A cycle-level
//             behavioural model predicts ack_o, dat_o and int_req_o, which
//             are compared on every falling clock edge. Hand-computed literal
//             checks pin register readbacks and interrupt timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gumnut_port_timer;

  localparam logic [7:0] BASE = 8'hF0;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       cyc     = 1'b0;
  logic       stb     = 1'b0;
  logic       we      = 1'b0;
  logic [7:0] adr     = 8'h00;
  logic [7:0] dat     = 8'h00;
  logic       int_ack = 1'b0;
  logic       ack;
  logic [7:0] dout;
  logic       irq;

  int n_cmp    = 0;
  int n_err    = 0;
  int cycle_no = 0;

  gumnut_port_timer #(.BASE_ADDR(8'hF0), .RESET_RELOAD(8'hFF)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .cyc_i     (cyc),
    .stb_i     (stb),
    .we_i      (we),
    .adr_i     (adr),
    .dat_i     (dat),
    .ack_o     (ack),
    .dat_o     (dout),
    .int_ack_i (int_ack),
    .int_req_o (irq)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // The prescaler is tracked as "cycles left until the next tick".
  logic [2:0] m_ctrl;
  logic       m_exp;
  logic [7:0] m_reload, m_count, m_pre, m_left, m_dout;
  logic       m_ack, m_irq;
  logic       mh, mw, mt, mx;
  logic [7:0] moff;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    logic [7:0] o;
    o = a - BASE;
    case (o)
      8'd0:    return {5'd0, m_ctrl};
      8'd1:    return {6'd0, m_ctrl[0], m_exp};
      8'd2:    return m_reload;
      8'd3:    return m_count;
      8'd4:    return m_pre;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    mh   = cyc && stb && !m_ack && (adr >= BASE) && (adr <= BASE + 8'd4);
    mw   = mh && we;
    moff = adr - BASE;
    mt   = m_ctrl[0] && (m_left == 8'd0);
    mx   = mt && (m_count == 8'd0);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctrl <= 3'd0;  m_exp <= 1'b0;  m_reload <= 8'hFF; m_count <= 8'hFF;
      m_pre  <= 8'h00; m_left <= 8'h00; m_ack <= 1'b0; m_dout <= 8'h00;
      m_irq  <= 1'b0;
    end else begin
      m_ack  <= mh;
      m_dout <= (mh && !we) ? m_read(adr) : 8'h00;
      m_irq  <= m_exp && m_ctrl[2];
      if (mw && moff == 8'd2) m_reload <= dat;
      if (mw && moff == 8'd4) m_pre <= dat;
      if (mw && moff == 8'd4)          m_left <= dat;
      else if (!m_ctrl[0] || mt)       m_left <= m_pre;
      else                             m_left <= m_left - 8'd1;
      if (mw && moff == 8'd3)          m_count <= dat;
      else if (mt)                     m_count <= (m_count != 8'd0) ? m_count - 8'd1
                                                  : (m_ctrl[1] ? m_reload : 8'h00);
      if (mw && moff == 8'd0)          m_ctrl <= dat[2:0];
      else if (mx && !m_ctrl[1])       m_ctrl[0] <= 1'b0;
      if (mx)                          m_exp <= 1'b1;
      else if (int_ack || (mw && moff == 8'd1 && dat[0])) m_exp <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- checks
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output to the model.
  task automatic step();
    @(negedge clk);
    cycle_no++;
    check("ack_vs_model",  {7'd0, ack}, {7'd0, m_ack});
    check("dout_vs_model", dout, m_dout);
    check("irq_vs_model",  {7'd0, irq}, {7'd0, m_irq});
  endtask

  task automatic wait_ack(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      step();
      if (ack) seen = 1'b1;
    end
    if (!seen) check({name, "_ack_timeout"}, 8'd0, 8'd1);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d;
    wait_ack("wr");
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string name);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    wait_ack(name);
    check(name, dout, exp);
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Wait (bounded) until the model says the coming edge is a tick, with an
  // optional requirement that the count is zero (i.e. an expiry edge).
  task automatic wait_tick_edge(input bit need_zero, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (m_ctrl[0] && m_left == 8'd0 && !m_ack && (!need_zero || m_count == 8'd0))
        ok = 1'b1;
      else
        step();
    end
    if (!ok) check({name, "_timeout"}, 8'd0, 8'd1);
  endtask

  task automatic wait_irq(input logic level, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (irq === level) ok = 1'b1;
    end
    if (!ok) check({name, "_timeout"}, 8'd0, 8'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int t0, rise1, rise2;
    logic [3:0] hold_pat;
    hold_pat = 4'b0101;

    #1 rst_n = 1'b0;
    repeat (3) step();
    check("rst_ack", {7'd0, ack}, 8'd0);
    check("rst_dout", dout, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'd0);
    rst_n = 1'b1;
    step();

    // Reset values
    bus_read(8'hF0, 8'h00, "rd_ctrl_rst");
    bus_read(8'hF1, 8'h00, "rd_status_rst");
    bus_read(8'hF2, 8'hFF, "rd_reload_rst");
    bus_read(8'hF3, 8'hFF, "rd_count_rst");
    bus_read(8'hF4, 8'h00, "rd_pre_rst");
    step();

    // Undecoded address: never acknowledged
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'hF5;
    repeat (4) begin
      step();
      check("no_ack_F5", {7'd0, ack}, 8'd0);
    end
    cyc = 1'b0; stb = 1'b0;

    // Held strobe: ack on alternate cycles
    cyc = 1'b1; stb = 1'b1; adr = 8'hF2;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_ack_pattern", {7'd0, ack}, {7'd0, hold_pat[i]});
    end
    cyc = 1'b0; stb = 1'b0;
    step(); step();

    // Auto-reload, period (3+1)*(1+1) = 8
    bus_write(8'hF2, 8'h03);
    bus_write(8'hF3, 8'h03);
    bus_write(8'hF4, 8'h01);
    bus_write(8'hF0, 8'h07);
    t0 = cycle_no;
    wait_irq(1'b1, "irq_first");
    rise1 = cycle_no;
    check("irq_first_latency", 8'(rise1 - t0), 8'd9);
    for (int r = 0; r < 2; r++) begin
      int_ack = 1'b1; step(); int_ack = 1'b0;
      step();
      check("irq_drop_after_ack", {7'd0, irq}, 8'd0);
      wait_irq(1'b1, "irq_repeat");
      rise2 = cycle_no;
      check("irq_period", 8'(rise2 - rise1), 8'd8);
      rise1 = rise2;
    end
    bus_write(8'hF0, 8'h00);
    bus_write(8'hF1, 8'h01);
    repeat (3) step();

    // One-shot: COUNT=2, PRESCALE=0 -> expiry on the third tick
    bus_write(8'hF4, 8'h00);
    bus_write(8'hF3, 8'h02);
    bus_write(8'hF0, 8'h05);
    repeat (6) step();
    check("oneshot_irq", {7'd0, irq}, 8'd1);
    bus_read(8'hF1, 8'h01, "oneshot_status");
    bus_read(8'hF3, 8'h00, "oneshot_count");
    repeat (3) step();
    bus_read(8'hF3, 8'h00, "oneshot_count_hold");
    bus_write(8'hF1, 8'h01);
    step();
    check("irq_w1c", {7'd0, irq}, 8'd0);

    // IE=0 masks the request but EXP still sets
    bus_write(8'hF3, 8'h01);
    bus_write(8'hF0, 8'h03);
    repeat (4) step();
    bus_read(8'hF1, 8'h03, "ie0_status");
    check("ie0_irq_low", {7'd0, irq}, 8'd0);
    bus_write(8'hF0, 8'h07);
    step();
    check("ie1_irq_high", {7'd0, irq}, 8'd1);
    bus_write(8'hF0, 8'h00);
    bus_write(8'hF1, 8'h01);
    repeat (3) step();

    // COUNT write on a tick edge wins over the decrement
    bus_write(8'hF4, 8'h02);
    bus_write(8'hF3, 8'h30);
    bus_write(8'hF0, 8'h01);
    wait_tick_edge(1'b0, "count_tick_align");
    bus_write(8'hF3, 8'h10);
    bus_read(8'hF3, 8'h10, "count_write_wins");
    bus_write(8'hF0, 8'h00);

    // int_ack coincident with expiry: set wins
    bus_write(8'hF4, 8'h00);
    bus_write(8'hF3, 8'h01);
    bus_write(8'hF0, 8'h05);
    wait_tick_edge(1'b1, "ack_exp_align");
    int_ack = 1'b1; step(); int_ack = 1'b0;
    step();
    check("exp_set_wins_irq", {7'd0, irq}, 8'd1);
    bus_read(8'hF1, 8'h01, "exp_set_wins_status");
    bus_write(8'hF1, 8'h01);

    // CTRL write on a one-shot expiry edge: written EN stands
    bus_write(8'hF4, 8'h02);
    bus_write(8'hF3, 8'h00);
    bus_write(8'hF0, 8'h01);
    wait_tick_edge(1'b1, "ctrl_exp_align");
    bus_write(8'hF0, 8'h01);
    bus_read(8'hF1, 8'h03, "ctrl_write_wins");
    bus_write(8'hF0, 8'h00);
    bus_write(8'hF1, 8'h01);

    // Reset in the middle of a running count with a pending ack
    bus_write(8'hF4, 8'h00);
    bus_write(8'hF2, 8'h03);
    bus_write(8'hF0, 8'h07);
    repeat (8) step();
    check("irq_before_rst", {7'd0, irq}, 8'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'hF3;
    step();
    check("ack_before_rst", {7'd0, ack}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ack", {7'd0, ack}, 8'd0);
    check("rst_async_irq", {7'd0, irq}, 8'd0);
    check("rst_async_dout", dout, 8'h00);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    bus_read(8'hF0, 8'h00, "rd_ctrl_after_rst");
    bus_read(8'hF1, 8'h00, "rd_status_after_rst");
    bus_read(8'hF2, 8'hFF, "rd_reload_after_rst");
    bus_read(8'hF3, 8'hFF, "rd_count_after_rst");
    bus_read(8'hF4, 8'h00, "rd_pre_after_rst");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
